// File: rtl/matriz_leds_param.sv
// matriz_leds_param -- parametrised LED-matrix puzzle controller.
//
// Holds a ROWS x COLS LED state. A rising edge on any button XORs that button's
// toggle mask into the state. Rows are multiplexed with a SCAN_DIV-cycle row
// period. A sequential engine compares the matrix against a loadable target one
// row per cycle and reports the result on nivel_concluido.
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   botoes          debounced button levels (N_BTN)
//   tgt_we          target row write strobe
//   tgt_row         target row index (writes with tgt_row >= ROWS are ignored)
//   tgt_data        target row pattern
//   nivel_concluido registered "matrix equals target" flag
//   jogadas         accepted move count, saturating at 255
//   colunas         column drive of the active row, active-high
//   linhas          row select, active-low, one-cold
//
// Build option: define SCAN_BLANK_EN to blank the display (linhas all 1s,
// colunas 0) during the last cycle of every row period.

module matriz_leds_param #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int N_BTN    = 8,
  parameter int SCAN_DIV = 1000,
  parameter logic [N_BTN*ROWS*COLS-1:0] BTN_MASKS = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_BTN-1:0]        botoes,
  input  logic                    tgt_we,
  input  logic [$clog2(ROWS)-1:0] tgt_row,
  input  logic [COLS-1:0]         tgt_data,
  output logic                    nivel_concluido,
  output logic [7:0]              jogadas,
  output logic [COLS-1:0]         colunas,
  output logic [ROWS-1:0]         linhas
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {CMP_IDLE, CMP_CHECK, CMP_DONE} cmp_state_t;

  logic [N_BTN-1:0] botoes_prev;
  logic [N_BTN-1:0] press;
  logic [COLS-1:0]  led_q [ROWS];
  logic [COLS-1:0]  led_d [ROWS];
  logic [COLS-1:0]  tgt_q [ROWS];
  logic             tgt_accept;
  logic             change;
  logic             dirty_q;
  logic             dirty_clr;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cnt_last;
  logic [RW-1:0]    linha_q, linha_d;
  logic             blank_d;

  cmp_state_t       state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic             acc_q, acc_d;
  logic             nivel_d;
  logic             row_match;

  assign press      = botoes & ~botoes_prev;
  assign tgt_accept = tgt_we && ({1'b0, tgt_row} < (RW+1)'(ROWS));
  assign change     = (|press) || tgt_accept;
  assign row_match  = (led_q[row_q] == tgt_q[row_q]);

  // Buttons pressed in the same cycle combine by XOR, so shared LEDs cancel.
  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      led_d[r] = led_q[r];
      for (int unsigned b = 0; b < N_BTN; b++) begin
        if (press[b]) begin
          led_d[r] = led_d[r] ^ BTN_MASKS[b*ROWS*COLS + r*COLS +: COLS];
        end
      end
    end
  end

  always_comb begin
    cnt_last = (cnt_q == CW'(SCAN_DIV-1));
    cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
    linha_d  = linha_q;
    if (cnt_last) begin
      linha_d = (linha_q == RW'(ROWS-1)) ? '0 : linha_q + 1'b1;
    end
`ifdef SCAN_BLANK_EN
    blank_d = (cnt_d == CW'(SCAN_DIV-1));
`else
    blank_d = 1'b0;
`endif
  end

  // A change seen in DONE goes straight back to CHECK so that the result
  // always lands ROWS+2 cycles after the last change.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    acc_d     = acc_q;
    nivel_d   = nivel_concluido;
    dirty_clr = 1'b0;
    case (state_q)
      CMP_IDLE: begin
        if (dirty_q) begin
          state_d   = CMP_CHECK;
          row_d     = '0;
          acc_d     = 1'b1;
          dirty_clr = 1'b1;
        end
      end
      CMP_CHECK: begin
        if (dirty_q) begin
          row_d     = '0;
          acc_d     = 1'b1;
          dirty_clr = 1'b1;
        end else begin
          acc_d = acc_q & row_match;
          if (row_q == RW'(ROWS-1)) begin
            state_d = CMP_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      CMP_DONE: begin
        nivel_d = acc_q;
        if (dirty_q) begin
          state_d   = CMP_CHECK;
          row_d     = '0;
          acc_d     = 1'b1;
          dirty_clr = 1'b1;
        end else begin
          state_d = CMP_IDLE;
        end
      end
      default: state_d = CMP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= CMP_IDLE;
      row_q           <= '0;
      acc_q           <= 1'b0;
      nivel_concluido <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      acc_q           <= acc_d;
      nivel_concluido <= nivel_d;
    end
  end

  // Display outputs are registered from next-state values so they line up
  // with the counter/row registers and already show any toggle of this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      botoes_prev <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        led_q[r] <= '0;
        tgt_q[r] <= '0;
      end
      jogadas <= '0;
      dirty_q <= 1'b0;
      cnt_q   <= '0;
      linha_q <= '0;
      linhas  <= ~ROWS'(1);
      colunas <= '0;
    end else begin
      botoes_prev <= botoes;
      for (int unsigned r = 0; r < ROWS; r++) begin
        led_q[r] <= led_d[r];
      end
      if (tgt_accept) begin
        tgt_q[tgt_row] <= tgt_data;
      end
      if ((|press) && (jogadas != 8'hFF)) begin
        jogadas <= jogadas + 8'd1;
      end
      dirty_q <= change | (dirty_q & ~dirty_clr);
      cnt_q   <= cnt_d;
      linha_q <= linha_d;
      if (blank_d) begin
        linhas  <= '1;
        colunas <= '0;
      end else begin
        linhas  <= ~(ROWS'(1) << linha_d);
        colunas <= led_d[linha_d];
      end
    end
  end

endmodule

// File: tb/tb_matriz_leds_param.sv
// Self-checking bench for matriz_leds_param: randomized and directed stimulus,
// a behavioural reference model and a per-cycle scoreboard.
// ROWS=6 leaves tgt_row codes 6 and 7 available to exercise ignored writes.

module tb_matriz_leds_param;

  localparam int ROWS = 6;
  localparam int COLS = 8;
  localparam int NB   = 4;
  localparam int SD   = 4;
  localparam int RW   = $clog2(ROWS);

  // Button regions as rectangles:
  // b0 rows0-2 cols0-2, b1 rows2-4 cols0-2, b2 rows3-5 cols4-7, b3 column 3.
  function automatic bit in_rect(int b, int r, int c);
    case (b)
      0:       return (r <= 2) && (c <= 2);
      1:       return (r >= 2) && (r <= 4) && (c <= 2);
      2:       return (r >= 3) && (c >= 4);
      default: return (c == 3);
    endcase
  endfunction

  function automatic logic [NB*ROWS*COLS-1:0] mk_masks();
    logic [NB*ROWS*COLS-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (in_rect(b, r, c)) m[b*ROWS*COLS + r*COLS + c] = 1'b1;
    return m;
  endfunction

  localparam logic [NB*ROWS*COLS-1:0] MASKS = mk_masks();

  logic            clk = 1'b0;
  logic            rst;
  logic [NB-1:0]   botoes;
  logic            tgt_we;
  logic [RW-1:0]   tgt_row;
  logic [COLS-1:0] tgt_data;
  logic            nivel_concluido;
  logic [7:0]      jogadas;
  logic [COLS-1:0] colunas;
  logic [ROWS-1:0] linhas;

  matriz_leds_param #(
    .ROWS(ROWS), .COLS(COLS), .N_BTN(NB), .SCAN_DIV(SD), .BTN_MASKS(MASKS)
  ) dut (
    .clk(clk), .rst(rst), .botoes(botoes), .tgt_we(tgt_we), .tgt_row(tgt_row),
    .tgt_data(tgt_data), .nivel_concluido(nivel_concluido), .jogadas(jogadas),
    .colunas(colunas), .linhas(linhas)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS-1:0] lin;
    logic [COLS-1:0] col;
    logic [7:0]      jog;
    logic            niv;
  } exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    longint unsigned dl;
    bit              m;
  } pend_t;
  pend_t pend_q[$];

  // Reference model state
  bit [COLS-1:0]   m_led [ROWS];
  bit [COLS-1:0]   m_tgt [ROWS];
  bit [NB-1:0]     m_prev;
  int              m_jog;
  bit              m_niv;
  longint unsigned m_k;

  int n_chk  = 0;
  int n_pass = 0;
  longint unsigned cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
  endtask

  // Rules: a change at edge g yields a result at edge g+ROWS+2 reflecting the
  // matrix/target after g; a later change cancels it unless it comes within
  // the last cycle before the result.
  task automatic model_edge();
    bit [NB-1:0] press;
    bit changed, match;
    int lin_i;
    exp_t e;
    logic [ROWS-1:0] one;
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin m_led[r] = '0; m_tgt[r] = '0; end
      m_prev = '0; m_jog = 0; m_niv = 1'b0; m_k = 0;
      pend_q.delete();
    end else begin
      m_k++;
      if (pend_q.size() > 0 && pend_q[0].dl == m_k) begin
        m_niv = pend_q[0].m;
        void'(pend_q.pop_front());
      end
      press  = botoes & ~m_prev;
      m_prev = botoes;
      changed = 1'b0;
      if (press != 0) begin
        for (int b = 0; b < NB; b++)
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              if (press[b] && in_rect(b, r, c)) m_led[r][c] = ~m_led[r][c];
        if (m_jog < 255) m_jog++;
        changed = 1'b1;
      end
      if (tgt_we && int'(tgt_row) < ROWS) begin
        m_tgt[tgt_row] = tgt_data;
        changed = 1'b1;
      end
      if (changed) begin
        while (pend_q.size() > 0 && pend_q[$].dl >= m_k + 2) void'(pend_q.pop_back());
        match = 1'b1;
        for (int r = 0; r < ROWS; r++) if (m_led[r] != m_tgt[r]) match = 1'b0;
        pend_q.push_back('{dl: m_k + ROWS + 2, m: match});
      end
    end
    lin_i = int'((m_k / SD) % ROWS);
    one   = 1;
    e.lin = ~(one << lin_i);
    e.col = m_led[lin_i];
`ifdef SCAN_BLANK_EN
    if ((m_k % SD) == SD - 1) begin
      e.lin = '1;
      e.col = '0;
    end
`endif
    e.jog = 8'(m_jog);
    e.niv = m_niv;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [NB-1:0] b, input logic we,
                      input logic [RW-1:0] row, input logic [COLS-1:0] d);
    @(negedge clk);
    rst = r; botoes = b; tgt_we = we; tgt_row = row; tgt_data = d;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  // Monitor: every cycle the DUT presents a fresh output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("linhas", 32'(linhas), 32'(e.lin));
        chk("colunas", 32'(colunas), 32'(e.col));
        chk("jogadas", 32'(jogadas), 32'(e.jog));
        chk("nivel_concluido", 32'(nivel_concluido), 32'(e.niv));
      end
    end
  end

  initial begin
    logic [NB-1:0] bot_r;
    rst = 1'b1; botoes = '0; tgt_we = 1'b0; tgt_row = '0; tgt_data = '0;
    step(1'b1, '0, 1'b0, '0, '0);
    step(1'b1, '0, 1'b0, '0, '0);
    idle(30);
    // held button toggles once, then a second press
    repeat (10) step(1'b0, 4'b0001, 1'b0, '0, '0);
    idle(3);
    repeat (2) step(1'b0, 4'b0001, 1'b0, '0, '0);
    idle(14);
    // overlapping masks pressed together
    step(1'b0, 4'b0011, 1'b0, '0, '0);
    idle(14);
    // win then lose
    step(1'b1, '0, 1'b0, '0, '0);
    for (int r = 0; r < 3; r++) step(1'b0, '0, 1'b1, RW'(r), 8'h07);
    idle(12);
    repeat (2) step(1'b0, 4'b0001, 1'b0, '0, '0);
    idle(12);
    step(1'b0, 4'b0001, 1'b0, '0, '0);
    idle(12);
    // out-of-range target rows are ignored
    step(1'b0, '0, 1'b1, 3'd6, 8'hFF);
    step(1'b0, '0, 1'b1, 3'd7, 8'hFF);
    idle(12);
    step(1'b0, 4'b0001, 1'b0, '0, '0);
    idle(12);
    // restart mid-check, and a change one cycle before the result
    step(1'b0, 4'b1000, 1'b0, '0, '0);
    idle(4);
    step(1'b0, 4'b0100, 1'b0, '0, '0);
    idle(15);
    step(1'b0, 4'b1000, 1'b0, '0, '0);
    idle(ROWS);
    step(1'b0, 4'b1000, 1'b0, '0, '0);
    idle(14);
    // saturation
    repeat (300) begin
      step(1'b0, 4'b0100, 1'b0, '0, '0);
      step(1'b0, '0, 1'b0, '0, '0);
    end
    idle(4);
    // reset during a check
    step(1'b0, 4'b0010, 1'b0, '0, '0);
    idle(3);
    step(1'b1, '0, 1'b0, '0, '0);
    idle(5);
    // randomized phase
    bot_r = '0;
    repeat (2000) begin
      logic r_rst, r_we;
      if ($urandom_range(3) == 0) bot_r = NB'($urandom);
      r_rst = ($urandom_range(299) == 0);
      r_we  = ($urandom_range(7) == 0);
      step(r_rst, bot_r, r_we, RW'($urandom_range(7)), COLS'($urandom));
    end
    idle(12);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
